// File: rtl/boa_wbuf_pkg.sv
// Shared types for the posted-write buffer: queued entry layout and
// the per-cycle request class seen on the upstream port.
package boa_wbuf_pkg;

    // Address width used for the default entry layout; instances with a
    // different address width build their own entry with matching fields.
    localparam int wbuf_alen = 16;

    typedef struct packed {
        logic [wbuf_alen-1:0] addr;
        logic [3:0]           we;
        logic [31:0]          wdata;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_READ,
        REQ_WRITE
    } req_class_t;

    // A read wins over any byte enables; a write needs at least one lane.
    function automatic req_class_t classify(input logic re, input logic [3:0] we);
        if (re) begin
            return REQ_READ;
        end else if (we != 4'h0) begin
            return REQ_WRITE;
        end
        return REQ_IDLE;
    endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Simple single-cycle-request memory bus shared by the CPU port and the
// external SRAM controller. The master holds re/we/addr/wdata stable until
// the slave raises ready; ready and rdata belong to the same cycle.
interface boa_mem_bus #(parameter int alen = 16);
    logic            re;
    logic [3:0]      we;
    logic [alen-1:0] addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            ready;

    modport MEM (input re, input we, input addr, input wdata, output rdata, output ready);
    modport CPU (output re, output we, output addr, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_wbuf_fifo.sv
// Generic register FIFO with async reset. The occupancy counter is the
// only source of full/empty; pointers simply wrap.
module boa_wbuf_fifo
    import boa_wbuf_pkg::*;
#(
    parameter int width = $bits(wbuf_entry_t),
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [width-1:0]           din,
    output logic [width-1:0]           dout,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != cw'(depth));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + cw'(1);
            end else if (do_pop && !do_push) begin
                count <= count - cw'(1);
            end
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/boa_mem_write_buffer.sv
// Posted-write buffer between the CPU data port and the external SRAM
// controller. Writes retire into the FIFO immediately while space exists;
// reads wait until every earlier write has drained, then pass straight
// through so read latency is that of the controller alone.
module boa_mem_write_buffer
    import boa_wbuf_pkg::*;
#(
    parameter int alen  = 16,
    parameter int depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    boa_mem_bus.MEM                    cpu,
    boa_mem_bus.CPU                    xm,
    output logic                       drained,
    output logic [$clog2(depth+1)-1:0] count
);

    localparam int cw = $clog2(depth + 1);

    typedef struct packed {
        logic [alen-1:0] addr;
        logic [3:0]      we;
        logic [31:0]     wdata;
    } entry_t;

    req_class_t req;
    entry_t     push_e;
    entry_t     head_e;
    logic       push;
    logic       pop;
    logic       empty;
    logic       full;

    assign req     = classify(cpu.re, cpu.we);
    assign empty   = (count == '0);
    assign full    = (count == cw'(depth));
    assign drained = empty;
    assign push_e  = '{addr: cpu.addr, we: cpu.we, wdata: cpu.wdata};
    assign pop     = !rst && !empty && xm.ready;

    boa_wbuf_fifo #(
        .width ($bits(entry_t)),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_e),
        .dout  (head_e),
        .count (count)
    );

    // Downstream drive: queued writes own the bus; only an empty FIFO lets
    // a read through. Everything idles to zero otherwise and during reset.
    always_comb begin
        xm.re    = 1'b0;
        xm.we    = 4'h0;
        xm.addr  = '0;
        xm.wdata = '0;
        if (!rst) begin
            if (!empty) begin
                xm.addr  = head_e.addr;
                xm.we    = head_e.we;
                xm.wdata = head_e.wdata;
            end else if (req == REQ_READ) begin
                xm.re   = 1'b1;
                xm.addr = cpu.addr;
            end
        end
    end

    // Upstream response: writes are accepted on free space alone (a pop in
    // the same cycle does not count), reads see the controller's handshake
    // only once the FIFO is empty.
    always_comb begin
        cpu.ready = 1'b0;
        cpu.rdata = '0;
        push      = 1'b0;
        if (!rst) begin
            if (req == REQ_WRITE && !full) begin
                push      = 1'b1;
                cpu.ready = 1'b1;
            end else if (req == REQ_READ && empty) begin
                cpu.ready = xm.ready;
                cpu.rdata = xm.rdata;
            end
        end
    end

endmodule

// File: tb/tb_boa_mem_write_buffer.sv
// Directed bench for boa_mem_write_buffer: a combinational vector table at
// empty FIFO, then hand-written multi-cycle sequences, with a scoreboard
// checking every write that completes downstream.
module tb_boa_mem_write_buffer;

    logic        clk;
    logic        rst;
    logic        drained;
    logic [2:0]  count;

    boa_mem_bus #(.alen(16)) cpu_bus ();
    boa_mem_bus #(.alen(16)) xm_bus ();

    boa_mem_write_buffer #(.alen(16), .depth(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (cpu_bus),
        .xm      (xm_bus),
        .drained (drained),
        .count   (count)
    );

    int errors = 0;
    int checks = 0;
    logic [51:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- downstream SRAM model ----------------
    // Raises ready after lat waiting cycles of an active request; reads echo addr.
    int   lat = 0;
    logic stall = 1'b0;
    int   wait_cnt;
    logic xm_active;

    assign xm_active      = xm_bus.re || (xm_bus.we != 4'h0);
    assign xm_bus.ready   = xm_active && !stall && (wait_cnt >= lat);
    assign xm_bus.rdata   = (xm_bus.re && xm_bus.ready) ? {16'h0, xm_bus.addr} : 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (xm_active && !xm_bus.ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write completing downstream must be the oldest accepted one.
    always begin
        @(negedge clk);
        #4;
        if (!rst && xm_bus.ready && (xm_bus.we != 4'h0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_write: got addr=%0h we=%0h wdata=%0h expected none",
                         xm_bus.addr, xm_bus.we, xm_bus.wdata);
            end else begin
                chk("drain_entry", {12'h0, xm_bus.addr, xm_bus.we, xm_bus.wdata},
                    {12'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_idle();
        cpu_bus.re    = 1'b0;
        cpu_bus.we    = 4'h0;
        cpu_bus.addr  = 16'h0;
        cpu_bus.wdata = 32'h0;
    endtask

    // Present a write from the next negedge until it is accepted.
    task automatic wr(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        cpu_bus.re = 1'b0; cpu_bus.we = w; cpu_bus.addr = a; cpu_bus.wdata = d;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cpu_bus.ready) begin
                exp_q.push_back({a, w, d});
                @(posedge clk);
                #1 cpu_idle();
                return;
            end
            @(negedge clk);
        end
        chk("wr_accept_timeout", 64'(cpu_bus.ready), 64'h1);
        cpu_idle();
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (drained && exp_q.size() == 0) break;
        end
        chk({name, "_drained"}, 64'(drained), 64'h1);
        chk({name, "_exp_empty"}, 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        re;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        e_ready;
        logic        e_xre;
        logic [3:0]  e_xwe;
        logic [15:0] e_xaddr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[5];

    int stall_cycles;
    int lat_cycles;

    initial begin
        vecs[0] = '{1'b0, 4'h0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0};
        vecs[1] = '{1'b1, 4'h0, 16'h0022, 32'h0000_0000, 1'b1, 1'b1, 4'h0, 16'h0022, 32'h22};
        vecs[2] = '{1'b1, 4'hF, 16'h0005, 32'h0000_0099, 1'b1, 1'b1, 4'h0, 16'h0005, 32'h05};
        vecs[3] = '{1'b0, 4'h3, 16'h0007, 32'h0000_1234, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0};
        vecs[4] = '{1'b0, 4'h0, 16'h01FF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 16'h0000, 32'h0};

        rst = 1'b1;
        cpu_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_ready", 64'(cpu_bus.ready), 64'h0);
        chk("rst_cpu_rdata", 64'(cpu_bus.rdata), 64'h0);
        chk("rst_xm_fields", {27'h0, xm_bus.re, xm_bus.we, xm_bus.addr, xm_bus.wdata[15:0]}, 64'h0);
        chk("rst_xm_wdata", 64'(xm_bus.wdata), 64'h0);
        chk("rst_drained", 64'(drained), 64'h1);
        chk("rst_count", 64'(count), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational behaviour with an empty FIFO; inputs withdrawn before the edge.
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_bus.re = vecs[i].re; cpu_bus.we = vecs[i].we;
            cpu_bus.addr = vecs[i].addr; cpu_bus.wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_cpu_ready", i), 64'(cpu_bus.ready), 64'(vecs[i].e_ready));
            chk($sformatf("vec%0d_xm_re", i), 64'(xm_bus.re), 64'(vecs[i].e_xre));
            chk($sformatf("vec%0d_xm_we", i), 64'(xm_bus.we), 64'(vecs[i].e_xwe));
            chk($sformatf("vec%0d_xm_addr", i), 64'(xm_bus.addr), 64'(vecs[i].e_xaddr));
            chk($sformatf("vec%0d_xm_wdata", i), 64'(xm_bus.wdata), 64'h0);
            chk($sformatf("vec%0d_cpu_rdata", i), 64'(cpu_bus.rdata), 64'(vecs[i].e_rdata));
            chk($sformatf("vec%0d_drained", i), 64'(drained), 64'h1);
            #1 cpu_idle();
        end
        @(negedge clk);
        #1 chk("vec_count_after", 64'(count), 64'h0);

        // Single posted write, downstream ready after 3 waiting cycles.
        lat = 3;
        @(negedge clk);
        cpu_bus.we = 4'hF; cpu_bus.addr = 16'h0002; cpu_bus.wdata = 32'hdead_beef;
        #1;
        chk("single_ready", 64'(cpu_bus.ready), 64'h1);
        chk("single_count_pre", 64'(count), 64'h0);
        chk("single_xm_not_yet", 64'(xm_bus.we), 64'h0);
        exp_q.push_back({16'h0002, 4'hF, 32'hdead_beef});
        @(posedge clk);
        #1 cpu_idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("single_xm_c%0d", k), {xm_bus.addr, xm_bus.we, 12'h0, xm_bus.wdata},
                {16'h0002, 4'hF, 12'h0, 32'hdead_beef});
            chk($sformatf("single_count_c%0d", k), 64'(count), 64'h1);
            chk($sformatf("single_drained_c%0d", k), 64'(drained), 64'h0);
        end
        @(negedge clk);
        #1;
        chk("single_count_post", 64'(count), 64'h0);
        chk("single_drained_post", 64'(drained), 64'h1);
        chk("single_xm_idle", 64'(xm_bus.we), 64'h0);

        // Fill to full with downstream stalled, then release.
        lat = 0;
        stall = 1'b1;
        wr(16'd0, 4'hF, 32'h1000_0000);
        wr(16'd4, 4'h1, 32'h1000_0004);
        wr(16'd8, 4'h2, 32'h1000_0008);
        wr(16'd12, 4'hC, 32'h1000_000C);
        @(negedge clk);
        cpu_bus.we = 4'hF; cpu_bus.addr = 16'd16; cpu_bus.wdata = 32'h1000_0010;
        #1;
        chk("full_count", 64'(count), 64'h4);
        chk("full_ready", 64'(cpu_bus.ready), 64'h0);
        chk("full_head_addr", 64'(xm_bus.addr), 64'h0);
        stall = 1'b0;
        #1;
        chk("full_no_bypass", 64'(cpu_bus.ready), 64'h0);
        wr(16'd16, 4'hF, 32'h1000_0010);
        wait_drained("fill");

        // Read stalls behind two queued writes, then passes through.
        lat = 1;
        wr(16'h0020, 4'hF, 32'hAAAA_0020);
        wr(16'h0024, 4'h3, 32'hBBBB_0024);
        @(negedge clk);
        cpu_bus.re = 1'b1; cpu_bus.addr = 16'd18;
        stall_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (count == 3'd0) break;
            chk("rd_stall_ready", 64'(cpu_bus.ready), 64'h0);
            chk("rd_stall_xm_re", 64'(xm_bus.re), 64'h0);
            stall_cycles++;
            @(negedge clk);
        end
        chk("rd_stall_cycles", 64'(stall_cycles), 64'h3);
        chk("rd_pass_xm", {xm_bus.re, xm_bus.we, xm_bus.addr}, {1'b1, 4'h0, 16'd18});
        lat_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_bus.ready) break;
            lat_cycles++;
            @(negedge clk);
            #1;
        end
        chk("rd_after_wr_latency", 64'(lat_cycles), 64'h1);
        chk("rd_after_wr_rdata", 64'(cpu_bus.rdata), 64'd18);
        cpu_idle();

        // Read with empty FIFO: passthrough, latency of the model alone.
        lat = 2;
        @(negedge clk);
        cpu_bus.re = 1'b1; cpu_bus.addr = 16'd34;
        #1;
        chk("rd_empty_xm", {xm_bus.re, xm_bus.we, xm_bus.addr}, {1'b1, 4'h0, 16'd34});
        lat_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            chk("rd_empty_drained", 64'(drained), 64'h1);
            if (cpu_bus.ready) break;
            lat_cycles++;
            @(negedge clk);
            #1;
        end
        chk("rd_empty_latency", 64'(lat_cycles), 64'h2);
        chk("rd_empty_rdata", 64'(cpu_bus.rdata), 64'd34);
        cpu_idle();

        // Full-rate write stream with downstream always ready.
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_bus.we = 4'(i + 1); cpu_bus.addr = 16'(16'h0100 + 4 * i);
            cpu_bus.wdata = 32'h5000_0000 + 32'(i);
            #1;
            chk($sformatf("stream_ready%0d", i), 64'(cpu_bus.ready), 64'h1);
            chk($sformatf("stream_count%0d", i), 64'(count), (i == 0) ? 64'h0 : 64'h1);
            exp_q.push_back({cpu_bus.addr, cpu_bus.we, cpu_bus.wdata});
            @(posedge clk);
        end
        #1 cpu_idle();
        wait_drained("stream");

        // Asynchronous reset with three entries queued.
        stall = 1'b1;
        wr(16'h0040, 4'hF, 32'hC000_0040);
        wr(16'h0044, 4'hF, 32'hC000_0044);
        wr(16'h0048, 4'hF, 32'hC000_0048);
        @(negedge clk);
        #1;
        chk("arst_pre_count", 64'(count), 64'h3);
        chk("arst_pre_xm_we", 64'(xm_bus.we), 64'hF);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_xm_we", 64'(xm_bus.we), 64'h0);
        chk("arst_xm_addr", 64'(xm_bus.addr), 64'h0);
        chk("arst_xm_wdata", 64'(xm_bus.wdata), 64'h0);
        chk("arst_cpu_ready", 64'(cpu_bus.ready), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_drained", 64'(drained), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("arst_post_count", 64'(count), 64'h0);
        chk("arst_post_drained", 64'(drained), 64'h1);
        chk("arst_post_xm_we", 64'(xm_bus.we), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
